// File: rtl/mod11_accumulator.sv
// Modular (mod MODULUS) add/subtract/load accumulator behind a one-deep valid/ready result register.
// Define MOD11_WRAP_COUNT_EN to add the saturating 8-bit wrap_cnt output.
module mod11_accumulator #(
  parameter int MODULUS = 11,
  parameter int W       = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_s,
  input  logic         in_clr,
  input  logic [W-1:0] in_x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_z,
`ifdef MOD11_WRAP_COUNT_EN
  output logic [7:0]   wrap_cnt,
`endif
  output logic         out_err
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [W:0] MOD_EXT = (W+1)'(MODULUS);

  state_t       state_q, state_d;
  logic [W-1:0] acc_q, acc_d;
  logic         err_q, err_d;
  logic         accept;
  logic         x_err;
  logic [W:0]   sum;
  logic [W:0]   diff;
  logic [W:0]   add_fix;
  logic [W:0]   sub_fix;
  logic         add_wrap;
  logic         sub_borrow;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: an accept always fills; a consume without refill empties.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = FULL;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  // Handshake outputs
  always_comb begin
    out_valid = (state_q == FULL);
    in_ready  = (state_q == EMPTY) || out_ready;
  end

  assign accept = in_valid && in_ready;
  assign x_err  = ({1'b0, in_x} >= MOD_EXT);

  // One conditional correction suffices since both operands lie in 0..MODULUS-1.
  always_comb begin
    sum        = {1'b0, acc_q} + {1'b0, in_x};
    diff       = {1'b0, acc_q} - {1'b0, in_x};
    add_wrap   = (sum >= MOD_EXT);
    sub_borrow = diff[W];
    add_fix    = add_wrap ? (sum - MOD_EXT) : sum;
    sub_fix    = sub_borrow ? (diff + MOD_EXT) : diff;
  end

  always_comb begin
    acc_d = acc_q;
    err_d = err_q;
    if (accept) begin
      err_d = x_err;
      if (!x_err) begin
        if (in_clr) begin
          acc_d = in_x;
        end else if (in_s) begin
          acc_d = sub_fix[W-1:0];
        end else begin
          acc_d = add_fix[W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      err_q <= err_d;
    end
  end

  assign out_z   = acc_q;
  assign out_err = err_q;

`ifdef MOD11_WRAP_COUNT_EN
  logic [7:0] wrap_q, wrap_d;
  logic       wrap_event;

  // A wrap is any valid add/subtract that needed the modular correction.
  always_comb begin
    wrap_event = accept && !x_err && !in_clr && (in_s ? sub_borrow : add_wrap);
    wrap_d     = wrap_q;
    if (accept && !x_err && in_clr) begin
      wrap_d = '0;
    end else if (wrap_event && wrap_q != 8'hFF) begin
      wrap_d = wrap_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= '0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap_cnt = wrap_q;
`endif

endmodule

// File: tb/tb_mod11_accumulator.sv
// Directed self-checking bench for mod11_accumulator using immediate assertions.
// wrap_cnt checks are compiled in only when MOD11_WRAP_COUNT_EN is defined.
module tb_mod11_accumulator;

  localparam int W = 4;
  localparam int MODULUS = 11;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_s;
  logic         in_clr;
  logic [W-1:0] in_x;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_z;
  logic         out_err;
`ifdef MOD11_WRAP_COUNT_EN
  logic [7:0]   wrap_cnt;
`endif

  int testsRun;
  int testsFailed;

  mod11_accumulator #(.MODULUS(MODULUS), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_clr    (in_clr),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
`ifdef MOD11_WRAP_COUNT_EN
    .wrap_cnt  (wrap_cnt),
`endif
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1ns after the rising edge.
  task automatic applyStimulus(input logic v, input logic s, input logic c,
                               input logic [W-1:0] x, input logic ordy);
    in_valid  = v;
    in_s      = s;
    in_clr    = c;
    in_x      = x;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkWrap(input string tag, input int expected);
`ifdef MOD11_WRAP_COUNT_EN
    checkOutput(tag, int'(wrap_cnt), expected);
`endif
  endtask

  initial begin
    int expZ;
    testsRun    = 0;
    testsFailed = 0;
    in_valid    = 1'b0;
    in_s        = 1'b0;
    in_clr      = 1'b0;
    in_x        = '0;
    out_ready   = 1'b0;

    // Reset with the clock idle
    rst = 1'b1;
    #2;
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset in_ready", int'(in_ready), 1);
    checkOutput("reset out_z", int'(out_z), 0);
    checkOutput("reset out_err", int'(out_err), 0);
    checkWrap("reset wrap_cnt", 0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Arithmetic sequence: clr 7, add 6, sub 5, sub 8
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd7, 1'b1);
    checkOutput("clr7 out_z", int'(out_z), 7);
    checkOutput("clr7 out_valid", int'(out_valid), 1);
    checkWrap("clr7 wrap_cnt", 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd6, 1'b1);
    checkOutput("add6 out_z", int'(out_z), 2);
    checkWrap("add6 wrap_cnt", 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd5, 1'b1);
    checkOutput("sub5 out_z", int'(out_z), 8);
    checkWrap("sub5 wrap_cnt", 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd8, 1'b1);
    checkOutput("sub8 out_z", int'(out_z), 0);
    checkOutput("sub8 out_err", int'(out_err), 0);
    checkWrap("sub8 wrap_cnt", 2);

    // Full sweep of every (acc, x) pair for add and subtract
    for (int op = 0; op < 2; op++) begin
      for (int a = 0; a < MODULUS; a++) begin
        for (int x = 0; x < MODULUS; x++) begin
          applyStimulus(1'b1, 1'b0, 1'b1, W'(a), 1'b1);
          applyStimulus(1'b1, op[0], 1'b0, W'(x), 1'b1);
          expZ = (op == 0) ? ((a + x) % MODULUS) : ((a - x + MODULUS) % MODULUS);
          checkOutput($sformatf("sweep op%0d a%0d x%0d", op, a, x), int'(out_z), expZ);
          checkOutput($sformatf("sweep range op%0d a%0d x%0d", op, a, x),
                      int'(out_z < W'(MODULUS)), 1);
        end
      end
    end

    // Out-of-range operand: accepted, acc and wrap_cnt unchanged, out_err flagged
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd9, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd6, 1'b1);
    checkOutput("pre-err out_z", int'(out_z), 4);
    checkWrap("pre-err wrap_cnt", 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd12, 1'b1);
    checkOutput("err out_err", int'(out_err), 1);
    checkOutput("err out_z", int'(out_z), 4);
    checkOutput("err out_valid", int'(out_valid), 1);
    checkWrap("err wrap_cnt", 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd3, 1'b1);
    checkOutput("post-err out_err", int'(out_err), 0);
    checkOutput("post-err out_z", int'(out_z), 7);
    checkWrap("post-err wrap_cnt", 1);

    // Backpressure: held result stays stable while in_ready is low
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_s      = 1'b0;
      in_clr    = 1'b0;
      in_x      = 4'd2;
      out_ready = 1'b0;
      #1;
      checkOutput($sformatf("bp%0d in_ready", i), int'(in_ready), 0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp%0d out_z", i), int'(out_z), 7);
      checkOutput($sformatf("bp%0d out_valid", i), int'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    checkOutput("release out_z", int'(out_z), 9);
    checkOutput("release out_valid", int'(out_valid), 1);

    // Drain without a new operation: EMPTY with acc retained
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    checkOutput("drain out_valid", int'(out_valid), 0);
    checkOutput("drain out_z", int'(out_z), 9);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("empty in_ready", int'(in_ready), 1);
    checkOutput("empty out_valid", int'(out_valid), 0);

    // Reset pulse while FULL discards the held result
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
    checkOutput("pre-rst out_z", int'(out_z), 10);
    checkOutput("pre-rst out_valid", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    checkOutput("mid-rst out_valid", int'(out_valid), 0);
    checkOutput("mid-rst out_z", int'(out_z), 0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd5, 1'b1);
    checkOutput("post-rst add5 out_z", int'(out_z), 5);
    checkOutput("post-rst out_valid", int'(out_valid), 1);

    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mod11_accumulator.md
MOD11_ACCUMULATOR -- requirements
Module: mod11_accumulator

Interface
REQ-001 SHALL have parameter MODULUS, default 11: the modulus of all arithmetic.
REQ-002 SHALL have parameter W, default 4: operand and result width; requires MODULUS <= 2**W.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: an operation is presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-007 SHALL have port in_s, input, 1 bit: operation select, 0 = add, 1 = subtract.
REQ-008 SHALL have port in_clr, input, 1 bit: load accumulator with in_x; overrides in_s.
REQ-009 SHALL have port in_x, input, W bits: operand.
REQ-010 SHALL have port out_valid, output, 1 bit: a result is held.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream takes the result.
REQ-012 SHALL have port out_z, output, W bits: accumulator value.
REQ-013 SHALL have port out_err, output, 1 bit: the result came from a rejected operand.

Function
REQ-014 SHALL implement a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 in_ready SHALL equal (state==EMPTY) || out_ready, a combinational pass-through with no skid.
REQ-016 Accept SHALL be in_valid && in_ready; on accept, next state is FULL and acc/out_err update at that edge (latency 1 cycle).
REQ-017 In FULL with out_ready=1 and no accept, next state SHALL be EMPTY; acc SHALL be retained.
REQ-018 Simultaneous consume and accept in FULL SHALL stay FULL with the new result and no bubble.
REQ-019 While FULL and out_ready=0, out_z and out_err SHALL be held stable.
REQ-020 clr: acc <= in_x. Add: acc <= (acc+in_x) mod MODULUS. Subtract: acc <= (acc-in_x) mod MODULUS, always in 0..MODULUS-1 (e.g. 2-5 -> 8).
REQ-021 Intermediate sums SHALL use W+1 bits. Reduction SHALL be a single conditional correction: subtract MODULUS if sum>=MODULUS; add MODULUS if the subtraction borrows.
REQ-022 If in_x >= MODULUS, the operation SHALL still be accepted, acc SHALL be unchanged and out_err SHALL be 1; otherwise out_err SHALL be 0.
REQ-023 out_z SHALL always reflect acc, including in EMPTY.

Reset
REQ-024 On rst assertion, asynchronously: state=EMPTY, acc=0, out_err=0, wrap_cnt=0; hence out_valid=0, out_z=0.
REQ-025 rst asserted mid-transaction SHALL discard any held result; the first accept after deassertion operates on acc=0.

Configuration
REQ-026 Macro MOD11_WRAP_COUNT_EN, when defined, SHALL add output port wrap_cnt, 8 bits: count of wraps.
REQ-027 A wrap SHALL be an accepted, non-error add with acc+in_x >= MODULUS, or subtract with acc < in_x.
REQ-028 wrap_cnt SHALL saturate at 255, reset to 0 on a valid clr, and be unchanged on error.
REQ-029 Without MOD11_WRAP_COUNT_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Reset check: assert rst with clk idle -> out_valid=0, in_ready=1, out_z=0, out_err=0 immediately.
REQ-031 Arithmetic: clr 7, add 6, sub 5, sub 8, with out_ready=1 -> out_z = 7, 2, 8, 0; wrap_cnt = 0, 1, 2, 2.
REQ-032 Range sweep: all 11x11 (acc, x) pairs for both add and subtract -> out_z matches the mod-11 reference model, and out_z is never >= 11.
REQ-033 Error: acc=4, add 12 -> out_err=1, out_z=4, wrap_cnt unchanged; the next add 3 -> out_err=0, out_z=7.
REQ-034 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_z stable; then out_ready=1 -> same-cycle accept and out_valid stays 1.
REQ-035 Reset mid-operation: rst pulse while FULL -> out_valid=0 and acc=0; then add 5 -> out_z=5.
